// File: rtl/fifo_packer.sv
// fifo_packer: drains bytes from an upstream FIFO and packs them little-endian into LANES-wide words
module fifo_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [WIDTH-1:0]           fifo_dout,
  input  logic                       flush,
  output logic [WIDTH*LANES-1:0]     out_data,
  output logic [$clog2(LANES+1)-1:0] out_bytes,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);
  localparam int CW = $clog2(LANES+1);
  localparam logic [CW-1:0] FULL = CW'(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES-1);
  typedef enum logic [1:0] {FILL, DRAIN, OUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, bytes_q, bytes_d;
  logic [WIDTH*LANES-1:0] data_q, data_d;
  logic rd_pend_q, flush_req_q, flush_req_d, run_q;
  logic accept, full, emit;
  assign out_valid = state_q == OUT;
  assign out_data = data_q;
  assign out_bytes = bytes_q;
  assign accept = out_valid && out_ready;
  assign full = rd_pend_q && (cnt_q == LAST);
  assign emit = flush_req_q && !rd_pend_q && !out_valid;
  assign busy = (cnt_q != '0) || rd_pend_q || flush_req_q || out_valid;
  // run_q keeps reads off until the first rising edge after reset release
  assign fifo_rd_en = run_q && !fifo_empty && !out_valid && !flush_req_q && ((cnt_q + CW'(rd_pend_q)) < FULL);
  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      bytes_q     <= '0;
      data_q      <= '0;
      rd_pend_q   <= 1'b0;
      flush_req_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bytes_q     <= bytes_d;
      data_q      <= data_d;
      rd_pend_q   <= fifo_rd_en;
      flush_req_q <= flush_req_d;
      run_q       <= 1'b1;
    end
  end
  // next state: capture into lane cnt, emit full or flushed partial words, clear on acceptance
  always_comb begin
    data_d      = data_q;
    cnt_d       = cnt_q;
    bytes_d     = bytes_q;
    flush_req_d = flush || (flush_req_q && !emit);
    if (accept) begin
      data_d  = '0;
      cnt_d   = '0;
      bytes_d = '0;
    end else if (rd_pend_q) begin
      for (int l = 0; l < LANES; l++)
        if (cnt_q == CW'(l)) data_d[l*WIDTH +: WIDTH] = fifo_dout;
      cnt_d   = cnt_q + CW'(1);
      bytes_d = full ? FULL : bytes_q;
    end else if (emit) begin
      bytes_d = cnt_q;
    end
    state_d = (full || (emit && cnt_q != '0)) ? OUT :
              (out_valid && !out_ready)       ? OUT :
              flush_req_d                     ? DRAIN : FILL;
  end
endmodule

// File: doc/fifo_packer.md
FIFO_PACKER -- requirements
Module: fifo_packer

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 8, FIFO byte width.
- LANES, default 4, bytes per output word (power of two, >= 2).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_dout  in  WIDTH  FIFO read data, valid the cycle after fifo_rd_en is sampled high.
- flush  in  1  single-cycle request to emit a partial word.
- out_data  out  WIDTH*LANES  packed word.
- out_bytes  out  $clog2(LANES+1)  number of valid lanes in out_data.
- out_valid  out  1  word available.
- out_ready  in  1  sink accepts word.
- busy  out  1  high when any byte is held, a read is outstanding, or a flush is pending.
REQ-003 Reset SHALL be one clock with asynchronous, active-low reset; there SHALL be no other clock or reset.

Function
REQ-004 The block SHALL drain bytes from the upstream FIFO and pack them little-endian: the first byte goes to out_data[WIDTH-1:0], byte k goes to lane k.
REQ-005 fifo_rd_en SHALL be combinational: !fifo_empty && !out_valid && !flush_req && (cnt + rd_pend < LANES).
REQ-006 rd_pend SHALL register fifo_rd_en, giving one cycle of read latency; back-to-back reads are permitted.
REQ-007 When rd_pend=1, fifo_dout SHALL be written into lane cnt and cnt SHALL increment on that edge.
REQ-008 If that capture makes cnt==LANES, out_valid SHALL rise on the same edge, with out_bytes=LANES and all lanes valid.
REQ-009 While out_valid=1, out_data and out_bytes SHALL hold stable and fifo_rd_en SHALL be 0.
REQ-010 On a cycle with out_valid && out_ready, the next edge SHALL clear out_valid and cnt, and zero the lane register.
REQ-011 flush sampled high SHALL set flush_req. While flush_req=1, reads are suppressed, and the outstanding read (if any) still completes.
REQ-012 When flush_req=1, rd_pend=0 and out_valid=0:
- if cnt>0: out_valid SHALL rise with out_bytes=cnt, unused lanes zero.
- if cnt==0: no word is produced.
- in both cases flush_req SHALL clear.
REQ-013 flush asserted while out_valid=1 SHALL be held in flush_req and applied after the current word is accepted.
REQ-014 The control FSM SHALL have states FILL (reading), DRAIN (flush_req set, waiting on rd_pend), and OUT (out_valid held). Transitions:
- FILL->OUT on the full-word capture.
- FILL->DRAIN on flush.
- DRAIN->OUT when a partial word is emitted.
- DRAIN->FILL when cnt==0.
- OUT->FILL on acceptance.
REQ-015 cnt SHALL be $clog2(LANES+1) bits wide and SHALL never exceed LANES.
REQ-016 fifo_empty high SHALL never produce fifo_rd_en. A FIFO going empty mid-word SHALL leave the partial bytes held indefinitely until more data arrives or a flush occurs.
REQ-017 busy SHALL equal (cnt!=0) || rd_pend || flush_req || out_valid.

Reset
REQ-018 While rst=0, these SHALL be 0: out_valid, out_data, out_bytes, fifo_rd_en (forced), cnt, rd_pend, flush_req, busy. The FSM SHALL be in FILL.
REQ-019 Reset asserted mid-operation SHALL discard held bytes and any outstanding read; the FIFO byte already strobed is lost.
REQ-020 After release, the first fifo_rd_en SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-021 Stream: 16 bytes 0x00..0x0F in the FIFO, out_ready=1 -> four words: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, each with out_bytes=4. Order and count exact, no extra words.
REQ-022 Backpressure: out_ready=0 for 6 cycles after out_valid rises -> out_valid held, out_data stable, fifo_rd_en=0 throughout. The word is accepted on the first out_ready=1 cycle.
REQ-023 Partial flush: bytes 0xAA, 0xBB, then FIFO empty, then flush pulse -> out_data=0x0000BBAA, out_bytes=2, exactly once.
REQ-024 Flush with cnt==0 and FIFO empty -> no out_valid; busy returns to 0 within 1 cycle. Flush coincident with an outstanding read of 0x11 -> out_data=0x00000011, out_bytes=1.
REQ-025 Reset mid-word after 3 bytes captured -> outputs 0 immediately. After release, bytes 0x20..0x23 -> out_data=0x23222120, with no stale lanes.
REQ-026 Empty FIFO for 20 cycles -> fifo_rd_en never asserted, out_valid=0.
